// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle ARM-subset datapath: sequences fetch/decode/execute,
// owns the NZCV flags register and evaluates condition codes in DECODE.
module multicycle_controller #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         Cond,
    input  logic [1:0]         Op,
    input  logic [5:0]         Funct,
    input  logic [3:0]         ALUFlags,
    output logic               PCWrite,
    output logic               MemWrite,
    output logic               RegWrite,
    output logic               IRWrite,
    output logic               AdrSrc,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         ImmSrc,
    output logic [1:0]         RegSrc,
    output logic [1:0]         ALUControl,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [STATE_W-1:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWRITE,
        MEMWB,
        EXECUTER,
        EXECUTEI,
        ALUWB,
        BRANCH
    } state_t;

    state_t     cur;
    state_t     nxt;
    logic [3:0] flags;
    logic       condex;
    logic       aluop;
    logic       dpvalid;
    logic [1:0] dpctl;
    logic       fn, fz, fc, fv;

    assign {fn, fz, fc, fv} = flags;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cur <= FETCH;
        else       cur <= nxt;
    end

    // Only the S-bit form of a data-processing op updates flags; logical ops keep C and V.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags <= 4'b0000;
        end else if ((cur == EXECUTER || cur == EXECUTEI) && Funct[0]) begin
            flags[3:2] <= ALUFlags[3:2];
            if (!dpctl[1]) flags[1:0] <= ALUFlags[1:0];
        end
    end

    always_comb begin
        case (Cond)
            4'b0000: condex = fz;
            4'b0001: condex = !fz;
            4'b0010: condex = fc;
            4'b0011: condex = !fc;
            4'b0100: condex = fn;
            4'b0101: condex = !fn;
            4'b0110: condex = fv;
            4'b0111: condex = !fv;
            4'b1000: condex = fc && !fz;
            4'b1001: condex = !fc || fz;
            4'b1010: condex = (fn == fv);
            4'b1011: condex = (fn != fv);
            4'b1100: condex = !fz && (fn == fv);
            4'b1101: condex = fz || (fn != fv);
            4'b1110: condex = 1'b1;
            default: condex = 1'b0;
        endcase
    end

    always_comb begin
        dpvalid = 1'b1;
        case (Funct[4:1])
            4'b0100: dpctl = 2'b00;
            4'b0010: dpctl = 2'b01;
            4'b0000: dpctl = 2'b10;
            4'b1100: dpctl = 2'b11;
            default: begin
                dpctl   = 2'b00;
                dpvalid = 1'b0;
            end
        endcase
    end

    // Failed conditions, Op=11 and unknown data-processing opcodes all collapse to a 2-cycle skip.
    always_comb begin
        nxt = FETCH;
        case (cur)
            FETCH: nxt = DECODE;
            DECODE: begin
                if (!condex) nxt = FETCH;
                else begin
                    case (Op)
                        2'b01:   nxt = MEMADR;
                        2'b10:   nxt = BRANCH;
                        2'b00:   nxt = !dpvalid ? FETCH : (Funct[5] ? EXECUTEI : EXECUTER);
                        default: nxt = FETCH;
                    endcase
                end
            end
            MEMADR:   nxt = Funct[0] ? MEMREAD : MEMWRITE;
            MEMREAD:  nxt = MEMWB;
            EXECUTER: nxt = ALUWB;
            EXECUTEI: nxt = ALUWB;
            default:  nxt = FETCH;
        endcase
    end

    always_comb begin
        PCWrite   = 1'b0;
        MemWrite  = 1'b0;
        RegWrite  = 1'b0;
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        aluop     = 1'b0;
        case (cur)
            FETCH: begin
                IRWrite   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                PCWrite   = 1'b1;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            MEMADR: ALUSrcB = 2'b01;
            MEMREAD: AdrSrc = 1'b1;
            MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            EXECUTER: aluop = 1'b1;
            EXECUTEI: begin
                ALUSrcB = 2'b01;
                aluop   = 1'b1;
            end
            ALUWB: RegWrite = 1'b1;
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = 1'b1;
            end
            default: ;
        endcase
    end

    assign ALUControl = aluop ? dpctl : 2'b00;
    assign ImmSrc     = Op;
    assign RegSrc     = {Op == 2'b01, Op == 2'b10};
    assign state      = cur;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- FSM that sequences the multicycle 32-bit ARM-subset datapath: instruction register, shared memory port, ALU, register file and the immediate extender.
- Decodes the registered instruction fields and emits one cycle-accurate set of control strobes per state.
- Holds the NZCV flags register and evaluates condition codes.
- Drives ImmSrc to the extender: 00 = 8-bit zero-extend, 01 = 12-bit zero-extend, 10 = 24-bit sign-extend shifted left by 2.

Parameters:
- STATE_W, 4, width of the state register and of the state debug output.

Ports:
- clk  input  1  system clock; all state and flags update on rising edge
- reset  input  1  asynchronous, active-high reset
- Cond  input  4  Instr[31:28] from instruction register
- Op  input  2  Instr[27:26]
- Funct  input  6  Instr[25:20]
- ALUFlags  input  4  {N,Z,C,V} from ALU, current cycle
- PCWrite  output  1  PC register enable
- MemWrite  output  1  memory write strobe
- RegWrite  output  1  register file write enable
- IRWrite  output  1  instruction register enable
- AdrSrc  output  1  memory address: 0 = PC, 1 = ALUOut
- ALUSrcA  output  1  0 = RD1 register, 1 = PC
- ALUSrcB  output  2  00 = RD2 register, 01 = ExtImm, 10 = constant 4
- ResultSrc  output  2  00 = ALUOut, 01 = Data register, 10 = ALU result direct
- ImmSrc  output  2  equals Op (combinational)
- RegSrc  output  2  {Op==01, Op==10}
- ALUControl  output  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- state  output  STATE_W  current state, debug

Behaviour:
- Reset (asynchronous): state = FETCH; Flags = 0000. All strobes are Moore-decoded from state, so after reset the outputs equal the FETCH values.
- Unlisted strobes are 0 in every state. ALUOp is internal: 1 means "decode ALUControl from Funct", 0 means ADD.
- State outputs:
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ALUOp=0, ResultSrc=10, PCWrite=1.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ALUOp=0, ResultSrc=10.
  - MEMADR: ALUSrcA=0, ALUSrcB=01, ALUOp=0.
  - MEMREAD: AdrSrc=1, ResultSrc=00.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - EXECUTER: ALUSrcA=0, ALUSrcB=00, ALUOp=1.
  - EXECUTEI: ALUSrcA=0, ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegWrite=1.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ALUOp=0, ResultSrc=10, PCWrite=1.
- State transitions:
  - FETCH -> DECODE, always.
  - DECODE -> FETCH if CondEx=0, Op=11, or the opcode is unsupported. Otherwise:
    - Op=01 -> MEMADR.
    - Op=00 with Funct[5]=1 -> EXECUTEI; with Funct[5]=0 -> EXECUTER.
    - Op=10 -> BRANCH.
  - MEMADR -> MEMREAD if Funct[0]=1, else MEMWRITE.
  - MEMREAD -> MEMWB.
  - EXECUTER / EXECUTEI -> ALUWB.
  - MEMWB, MEMWRITE, ALUWB, BRANCH -> FETCH.
- Latencies: branch 3 cycles; data-processing 4; STR 4; LDR 5; skipped instruction 2.
- Condition evaluation (CondEx), combinational from stored Flags, used only in DECODE:
  - EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V.
  - HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V).
  - AL (1110) = 1; 1111 = 0.
- ALU decode when ALUOp=1, from Funct[4:1]:
  - 0100 ADD -> 00; 0010 SUB -> 01; 0000 AND -> 10; 1100 ORR -> 11.
  - Any other Funct[4:1] is unsupported (NOP); DECODE returns to FETCH.
  - When ALUOp=0: ALUControl = 00.
- Flags register:
  - Written on the rising edge ending EXECUTER/EXECUTEI, only when Funct[0]=1.
  - N and Z are always loaded from ALUFlags[3:2].
  - C and V are loaded from ALUFlags[1:0] only for ADD/SUB; AND/ORR keep the old C and V.
  - Flags do not change in any other state.
- Inputs Cond/Op/Funct are stable from DECODE through writeback, because IRWrite is asserted only in FETCH.
- Reset asserted mid-instruction: the next state is FETCH immediately and no further strobe fires. A partially executed store is abandoned if reset arrives before MEMWRITE.

Test Plan:
- Reset pulse mid-EXECUTER -> state=FETCH asynchronously, Flags=0000; first post-reset cycle shows IRWrite=1, PCWrite=1, ALUSrcB=10.
- ADDS R-type, Cond=1110, Op=00, Funct=001001, ALUFlags=0110 -> FETCH, DECODE, EXECUTER (ALUControl=00), ALUWB (RegWrite=1); Flags become 0110.
- LDR, Op=01, Funct=011001 -> MEMADR (ImmSrc=01, ALUSrcB=01), MEMREAD (AdrSrc=1), MEMWB (ResultSrc=01, RegWrite=1); total 5 cycles, Flags unchanged.
- STR, Funct=011000 -> MEMADR then MEMWRITE with MemWrite=1 for exactly one cycle; RegWrite never asserts.
- BEQ with Flags Z=0, Cond=0000, Op=10 -> DECODE returns to FETCH, no BRANCH-state PCWrite; with Z=1 -> BRANCH with ImmSrc=10, PCWrite=1, ResultSrc=10.
- ANDS after Flags=0011, ALUFlags=1000 -> Flags=1011 (C and V preserved). Unsupported Funct[4:1]=1111 -> 2-cycle NOP, no RegWrite.
